// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch queue.
package fetch_pkg;
  localparam int                      XLEN_DEF     = 32;
  localparam int                      DEPTH_DEF    = 4;
  localparam int                      MAX_OUT_DEF  = 2;
  localparam logic [XLEN_DEF-1:0]     RESET_PC_DEF = '0;
  localparam int                      INSTR_STEP   = 4;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [31:0]         instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side bus: imem request/response, decode handoff and branch redirect.
interface fetch_queue_if #(parameter int XLEN = fetch_pkg::XLEN_DEF);
  logic            imem_req_valid_o;
  logic            imem_req_ready_i;
  logic [XLEN-1:0] imem_req_pc_o;
  logic            imem_resp_valid_i;
  logic [XLEN-1:0] imem_resp_pc_i;
  logic [31:0]     imem_resp_instr_i;
  logic            decode_valid_o;
  logic            decode_ready_i;
  logic [31:0]     decode_instr_o;
  logic [XLEN-1:0] decode_pc_o;
  logic            br_taken_i;
  logic [XLEN-1:0] br_tgt_addr_i;

  modport master (
    output imem_req_valid_o, imem_req_pc_o, decode_valid_o, decode_instr_o, decode_pc_o,
    input  imem_req_ready_i, imem_resp_valid_i, imem_resp_pc_i, imem_resp_instr_i,
           decode_ready_i, br_taken_i, br_tgt_addr_i
  );

  modport slave (
    input  imem_req_valid_o, imem_req_pc_o, decode_valid_o, decode_instr_o, decode_pc_o,
    output imem_req_ready_i, imem_resp_valid_i, imem_resp_pc_i, imem_resp_instr_i,
           decode_ready_i, br_taken_i, br_tgt_addr_i
  );
endinterface

// File: rtl/fetch_fifo.sv
// Power-of-two synchronous FIFO with flush; pointers carry one wrap bit.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH = DEPTH_DEF,
  parameter type T     = fetch_entry_t,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        push_i,
  input  T            din_i,
  input  logic        pop_i,
  output T            dout_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [AW:0] count_o
);
  T            mem_q [DEPTH];
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic        push_ok, pop_ok;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count_o = wptr_q - rptr_q;
  assign dout_o  = mem_q[rptr_q[AW-1:0]];

  assign push_ok = push_i && !flush_i;
  assign pop_ok  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wptr_d = wptr_q + (AW+1)'(push_ok);
    rptr_d = rptr_q + (AW+1)'(pop_ok);
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= din_i;
  end
endmodule

// File: rtl/fetch_queue.sv
// Credit-based instruction fetcher: issues sequential imem requests, filters
// responses against the expected PC and buffers them for decode.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int              XLEN            = XLEN_DEF,
  parameter int              DEPTH           = DEPTH_DEF,
  parameter int              MAX_OUTSTANDING = MAX_OUT_DEF,
  parameter logic [XLEN-1:0] RESET_PC        = XLEN'(RESET_PC_DEF)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  fetch_queue_if.master bus
);
  localparam int              CW      = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] STEP    = XLEN'(INSTR_STEP);
  localparam logic [CW:0]     DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [CW-1:0]   MAXO_C  = CW'(MAX_OUTSTANDING);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  logic [XLEN-1:0] req_pc_q, req_pc_d, exp_pc_q, exp_pc_d;
  logic [CW-1:0]   outst_q, outst_d, occ;
  logic            full, empty, credit, req_valid, dec_valid;
  logic            fire, resp_ok, push, pop, redirect;
  entry_t          head, din;

  assign redirect = bus.br_taken_i;

  // Queue slots are reserved at issue time, so occupancy+in-flight never exceeds DEPTH.
  assign credit    = (({1'b0, occ} + {1'b0, outst_q}) < DEPTH_C) && (outst_q < MAXO_C);
  assign req_valid = !rst_i && credit && !redirect;
  assign fire      = req_valid && bus.imem_req_ready_i;

  assign resp_ok = !rst_i && bus.imem_resp_valid_i && (outst_q != '0);
  assign push    = resp_ok && !redirect && (bus.imem_resp_pc_i == exp_pc_q);
  assign din     = '{pc: bus.imem_resp_pc_i, instr: bus.imem_resp_instr_i};

  assign dec_valid = !rst_i && !empty;
  assign pop       = dec_valid && bus.decode_ready_i;

  assign bus.imem_req_valid_o = req_valid;
  assign bus.imem_req_pc_o    = req_pc_q;
  assign bus.decode_valid_o   = dec_valid;
  assign bus.decode_pc_o      = dec_valid ? head.pc    : '0;
  assign bus.decode_instr_o   = dec_valid ? head.instr : '0;

  always_comb begin
    outst_d  = outst_q + CW'(fire) - CW'(resp_ok);
    req_pc_d = fire ? req_pc_q + STEP : req_pc_q;
    exp_pc_d = push ? exp_pc_q + STEP : exp_pc_q;
    if (redirect) begin
      req_pc_d = bus.br_tgt_addr_i;
      exp_pc_d = bus.br_tgt_addr_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_pc_q <= RESET_PC;
      exp_pc_q <= RESET_PC;
      outst_q  <= '0;
    end else begin
      req_pc_q <= req_pc_d;
      exp_pc_q <= exp_pc_d;
      outst_q  <= outst_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (redirect),
    .push_i  (push),
    .din_i   (din),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (occ)
  );

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && full && !pop));
  a_resp_with_credit: assert property (@(posedge clk_i) disable iff (rst_i)
    bus.imem_resp_valid_i |-> (outst_q != '0));
endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue with a queue-level reference model.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_queue_if #(.XLEN(32)) bus ();

  fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(32'h0)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct { logic [31:0] pc; int due; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

  int          n_chk = 0, n_err = 0, cyc = 0;
  pend_t       mem_q[$];
  logic [31:0] issued[$];
  bit          rnd_ready = 0, rnd_dready = 0, resp_en = 1;
  int          resp_pct = 100;

  logic [31:0] m_req, m_exp;
  int          m_out;
  ent_t        m_q[$];

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {pc[15:0], pc[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: advances on the abstract rules at each cycle midpoint.
  always @(negedge clk) begin
    bit ev, fire, pop, rok;
    if (rst) begin
      chk("rst_req_valid", bus.imem_req_valid_o, 0);
      chk("rst_dec_valid", bus.decode_valid_o, 0);
      chk("rst_dec_pc", bus.decode_pc_o, 0);
      chk("rst_dec_instr", bus.decode_instr_o, 0);
      m_req = 0; m_exp = 0; m_out = 0; m_q.delete();
    end else begin
      ev = (m_q.size() + m_out < DEPTH) && (m_out < MAXO) && !bus.br_taken_i;
      chk("req_valid", bus.imem_req_valid_o, ev);
      if (ev) chk("req_pc", bus.imem_req_pc_o, m_req);
      chk("dec_valid", bus.decode_valid_o, m_q.size() != 0);
      if (m_q.size() != 0) begin
        chk("dec_pc", bus.decode_pc_o, m_q[0].pc);
        chk("dec_instr", bus.decode_instr_o, m_q[0].instr);
      end
      fire = ev && bus.imem_req_ready_i;
      pop  = (m_q.size() != 0) && bus.decode_ready_i;
      rok  = bus.imem_resp_valid_i && (m_out > 0);
      if (pop) void'(m_q.pop_front());
      if (bus.br_taken_i) begin
        m_q.delete();
        m_req = bus.br_tgt_addr_i;
        m_exp = bus.br_tgt_addr_i;
      end else begin
        if (fire) m_req = m_req + 4;
        if (rok && bus.imem_resp_pc_i == m_exp) begin
          m_q.push_back('{pc: bus.imem_resp_pc_i, instr: bus.imem_resp_instr_i});
          m_exp = m_exp + 4;
        end
      end
      m_out = m_out + int'(fire) - int'(rok);
    end
    if (!rst && bus.imem_req_valid_o && bus.imem_req_ready_i) begin
      mem_q.push_back('{pc: bus.imem_req_pc_o, due: cyc + 1});
      issued.push_back(bus.imem_req_pc_o);
    end
  end

  // One clock step; also plays the in-order memory.
  task automatic tick();
    pend_t p;
    @(posedge clk); #1;
    cyc++;
    if (rnd_ready)  bus.imem_req_ready_i = ($urandom_range(0, 99) < 60);
    if (rnd_dready) bus.decode_ready_i   = ($urandom_range(0, 99) < 70);
    bus.imem_resp_valid_i = 1'b0;
    bus.imem_resp_pc_i    = $urandom;
    bus.imem_resp_instr_i = $urandom;
    if (resp_en && mem_q.size() > 0 && mem_q[0].due <= cyc &&
        $urandom_range(0, 99) < resp_pct) begin
      p = mem_q.pop_front();
      bus.imem_resp_valid_i = 1'b1;
      bus.imem_resp_pc_i    = p.pc;
      bus.imem_resp_instr_i = instr_of(p.pc);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.br_taken_i = 1'b0;
    mem_q.delete();
    issued.delete();
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    bus.imem_req_ready_i  = 1'b1;
    bus.decode_ready_i    = 1'b1;
    bus.imem_resp_valid_i = 1'b0;
    bus.imem_resp_pc_i    = '0;
    bus.imem_resp_instr_i = '0;
    bus.br_taken_i        = 1'b0;
    bus.br_tgt_addr_i     = '0;

    // Streaming after reset release
    do_reset();
    #1;
    chk("p1_first_req_valid", bus.imem_req_valid_o, 1);
    chk("p1_first_req_pc", bus.imem_req_pc_o, 32'h0);
    tick(); tick(); #1;
    chk("p1_c3_dec_valid", bus.decode_valid_o, 1);
    chk("p1_c3_dec_pc", bus.decode_pc_o, 32'h0);
    for (int i = 0; i < 10; i++) begin
      tick(); #1;
      chk("p1_sustained", bus.decode_valid_o, 1);
    end
    chk("p1_issue0", issued[0], 32'h0);
    chk("p1_issue1", issued[1], 32'h4);
    chk("p1_issue2", issued[2], 32'h8);

    // Decode stalled: credits stop issue at DEPTH
    bus.decode_ready_i = 1'b0;
    do_reset();
    repeat (12) tick();
    #1;
    chk("p2_issue_count", issued.size(), 4);
    chk("p2_req_stopped", bus.imem_req_valid_o, 0);
    bus.decode_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("p2_pop_valid", bus.decode_valid_o, 1);
      chk("p2_pop_pc", bus.decode_pc_o, 32'(i * 4));
      tick(); #1;
    end
    if (issued.size() > 4) chk("p2_resume_pc", issued[4], 32'h10);
    else chk("p2_resume_missing", issued.size(), 5);

    // Redirect with 0x8/0xC in flight
    bus.decode_ready_i = 1'b0;
    resp_en = 0;
    do_reset();
    repeat (3) tick();
    resp_en = 1;
    tick(); tick();
    resp_en = 0;
    tick(); tick();
    chk("p3_inflight_cnt", mem_q.size(), 2);
    if (mem_q.size() == 2) chk("p3_inflight_pc", mem_q[0].pc, 32'h8);
    bus.br_taken_i    = 1'b1;
    bus.br_tgt_addr_i = 32'h100;
    #1;
    chk("p3_issue_suppressed", bus.imem_req_valid_o, 0);
    tick();
    bus.br_taken_i = 1'b0;
    #1;
    chk("p3_flushed", bus.decode_valid_o, 0);
    resp_en = 1;
    bus.decode_ready_i = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(); #1;
      if (bus.decode_valid_o) begin
        chk("p3_first_after_redirect", bus.decode_pc_o, 32'h100);
        found = 1;
      end
    end
    if (!found) chk("p3_timeout", 0, 1);

    // Random traffic with random redirects
    rnd_ready = 1; rnd_dready = 1; resp_pct = 50;
    for (int i = 0; i < 400; i++) begin
      tick();
      bus.br_taken_i    = ($urandom_range(0, 99) < 5);
      bus.br_tgt_addr_i = 32'h200 + 32'($urandom_range(0, 15)) * 4;
    end
    rnd_ready = 0; rnd_dready = 0; resp_pct = 100;
    bus.imem_req_ready_i = 1'b1;
    bus.decode_ready_i   = 1'b1;

    // Back-to-back redirects: last wins
    bus.br_taken_i = 1'b1; bus.br_tgt_addr_i = 32'h300;
    tick();
    bus.br_taken_i = 1'b1; bus.br_tgt_addr_i = 32'h400;
    tick();
    bus.br_taken_i = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      #1;
      if (bus.decode_valid_o) begin
        chk("p4_last_redirect_wins", bus.decode_pc_o, 32'h400);
        found = 1;
      end
      tick();
    end
    if (!found) chk("p4_timeout", 0, 1);

    // Address wrap
    bus.br_taken_i = 1'b1; bus.br_tgt_addr_i = 32'hFFFF_FFF8;
    issued.delete();
    tick();
    bus.br_taken_i = 1'b0;
    repeat (12) tick();
    found = 0;
    for (int i = 0; i + 1 < issued.size(); i++) begin
      if (!found && issued[i] == 32'hFFFF_FFFC) begin
        chk("p5_wrap_next", issued[i+1], 32'h0);
        found = 1;
      end
    end
    if (!found) chk("p5_wrap_missing", 0, 1);

    // Reset mid-operation with queued and in-flight work
    bus.decode_ready_i = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (m_q.size() >= 2) found = 1;
    end
    resp_en = 0;
    repeat (3) tick();
    #1;
    chk("p6_pre_dec_valid", bus.decode_valid_o, 1);
    rst = 1'b1;
    mem_q.delete();
    issued.delete();
    bus.imem_resp_valid_i = 1'b1;
    bus.imem_resp_pc_i    = 32'h0;
    bus.imem_resp_instr_i = instr_of(32'h0);
    #1;
    chk("p6_rst_req_valid", bus.imem_req_valid_o, 0);
    chk("p6_rst_dec_valid", bus.decode_valid_o, 0);
    chk("p6_rst_dec_pc", bus.decode_pc_o, 0);
    resp_en = 1;
    tick(); tick();
    rst = 1'b0;
    bus.decode_ready_i = 1'b1;
    #1;
    chk("p6_restart_valid", bus.imem_req_valid_o, 1);
    chk("p6_restart_pc", bus.imem_req_pc_o, 32'h0);
    chk("p6_restart_dec_empty", bus.decode_valid_o, 0);
    repeat (20) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
